hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard detection and forwarding control for the 5-stage pipelined MIPS datapath.
- Consumes the datapath's register-tag and control taps from the D, E, M and W stages, plus the multiplier start/done pair.
- Produces stallF, stallD, flushE, forwardAD/BD and forwardAE/BE.
- Holds a small FSM that tracks the multicycle multiplier, so HI/LO readers and a second mult wait for completion.

Parameters:
MULT_MAX_CYCLES, 34, busy cycles allowed before the multiplier is declared hung.
CNT_W, 6, width of the busy counter; must hold MULT_MAX_CYCLES.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
branchD  in  2  D-stage branch type, 00 = none, nonzero = branch resolved in D
RsD, RtD  in  5 each  D-stage source registers
HiLoReadD  in  1  D instruction is mfhi/mflo
MultStartD  in  1  D instruction is mult/multu
RsE, RtE, WriteRegE  in  5 each  E-stage tags
RegWriteE  in  1  E writes register file
WBSrcE  in  3  E writeback source
MultStartE, MultDoneE  in  1 each  multiplier start (E) / done pulses
WriteRegM  in  5  M-stage destination
RegWriteM  in  1  M writes register file
WBSrcM  in  3  M writeback source
WriteRegW  in  5  W-stage destination
RegWriteW  in  1  W writes register file
stallF, stallD  out  1 each  hold PC and IF/ID registers
flushE  out  1  bubble the ID/EX register
forwardAD, forwardBD  out  1 each  D-stage comparator operand from ALUOutM
forwardAE, forwardBE  out  2 each  E operand select: 00 = regfile, 01 = ResultW, 10 = ALUOutM
mult_err  out  1  sticky, multiplier exceeded MULT_MAX_CYCLES
stall_cycles  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- WBSrc encoding: 000 ALU, 001 MEM, 010 LO, 011 HI, 100 LINK.
- Register 0 never matches in any comparison below.
- While rst is high: all outputs 0, FSM = IDLE, counter = 0, mult_err = 0.
- forwardAE (B analogous with RtE):
  - 10 if RegWriteM && WriteRegM == RsE;
  - else 01 if RegWriteW && WriteRegW == RsE;
  - else 00.
  - M has priority over W.
- forwardAD = RegWriteM && WriteRegM == RsD; forwardBD is the same with RtD.
- lwstall = WBSrcE == MEM && RegWriteE && (WriteRegE == RsD || WriteRegE == RtD).
- branchstall = branchD != 00 && ((RegWriteE && WriteRegE ∈ {RsD, RtD}) || (WBSrcM == MEM && RegWriteM && WriteRegM ∈ {RsD, RtD})).
- Multiplier FSM, states IDLE and BUSY; busy_now = (state == BUSY) || MultStartE.
  - IDLE: MultStartE → BUSY, counter = 1. MultDoneE in IDLE is ignored.
  - BUSY: counter increments each cycle.
  - BUSY: MultDoneE without MultStartE → IDLE, counter = 0.
  - BUSY: MultDoneE && MultStartE → stays BUSY, counter = 1 (back-to-back).
  - BUSY: counter reaches MULT_MAX_CYCLES without done → mult_err = 1 (sticky until rst), FSM → IDLE.
- multstall = (HiLoReadD || MultStartD) && busy_now.
  - It includes the MultDoneE cycle, because HI/LO are written at that edge.
  - Release occurs on the following cycle.
- stall = lwstall | branchstall | multstall; stallF = stallD = flushE = stall.
- All non-FSM outputs are combinational from the inputs and current state; the block adds no latency.
- rst asserted mid-multiply abandons the operation: FSM → IDLE immediately (asynchronous).

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cycles is a 32-bit counter.
  - Increments on each clk edge where stall = 1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by rst.
- Undefined: stall_cycles is tied to 0, and no counter logic is synthesised.

Test Plan:
- Forwarding: RegWriteM = 1, WriteRegM = 8, RegWriteW = 1, WriteRegW = 8, RsE = 8 → forwardAE = 10. Drop RegWriteM → 01. Set RsE = 0 → 00.
- Load-use: WBSrcE = 001, RegWriteE = 1, WriteRegE = 9, RtD = 9 → stallF = stallD = flushE = 1 for one cycle. Next cycle, with E flushed → all 0.
- Branch: branchD = 01, RsD = 4, RegWriteE = 1, WriteRegE = 4 → stall = 1. Then RegWriteM = 1, WriteRegM = 4, WBSrcM = 000 → stall = 0, forwardAD = 1.
- Multiply:
  - Pulse MultStartE; HiLoReadD = 1 for 20 cycles → stall = 1 for the start cycle through the MultDoneE cycle.
  - MultDoneE at cycle 20 → stall = 0 at cycle 21, FSM = IDLE.
- Timeout: MultStartE, never MultDoneE → mult_err = 1 after 34 cycles, FSM = IDLE. Assert rst mid-BUSY in a separate run → mult_err = 0, outputs 0 immediately.
- With HAZARD_PERF_EN: 3 load-use stalls plus a 20-cycle multstall → stall_cycles = 23. Without the macro → stall_cycles = 0.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: the register-tag and control taps from the D, E, M and W
// stages, the multiplier start/done pulses, and the stall/flush/forward
// controls returned to the datapath. The datapath side uses the master
// modport and the hazard unit uses the slave modport.
interface hazard_unit_if;
  // D-stage taps
  logic [1:0]  branchD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic        HiLoReadD;
  logic        MultStartD;
  // E-stage taps
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  WriteRegE;
  logic        RegWriteE;
  logic [2:0]  WBSrcE;
  logic        MultStartE;
  logic        MultDoneE;
  // M-stage taps
  logic [4:0]  WriteRegM;
  logic        RegWriteM;
  logic [2:0]  WBSrcM;
  // W-stage taps
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  // Controls back to the datapath
  logic        stallF;
  logic        stallD;
  logic        flushE;
  logic        forwardAD;
  logic        forwardBD;
  logic [1:0]  forwardAE;
  logic [1:0]  forwardBE;
  logic        mult_err;
  logic [31:0] stall_cycles;

  modport master (
    output branchD, RsD, RtD, HiLoReadD, MultStartD,
    output RsE, RtE, WriteRegE, RegWriteE, WBSrcE, MultStartE, MultDoneE,
    output WriteRegM, RegWriteM, WBSrcM,
    output WriteRegW, RegWriteW,
    input  stallF, stallD, flushE, forwardAD, forwardBD,
    input  forwardAE, forwardBE, mult_err, stall_cycles
  );

  modport slave (
    input  branchD, RsD, RtD, HiLoReadD, MultStartD,
    input  RsE, RtE, WriteRegE, RegWriteE, WBSrcE, MultStartE, MultDoneE,
    input  WriteRegM, RegWriteM, WBSrcM,
    input  WriteRegW, RegWriteW,
    output stallF, stallD, flushE, forwardAD, forwardBD,
    output forwardAE, forwardBE, mult_err, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Forwarding selects and the load-use / branch / multiplier stalls are purely
// combinational from the stage taps and the multiplier tracker state, so the
// unit adds no latency. A two-state tracker follows the multicycle multiplier
// so HI/LO readers and a second mult wait until the running one completes;
// a multiply that never signals done is abandoned after MULT_MAX_CYCLES busy
// cycles and flagged on the sticky mult_err output.
// Optional build macro HAZARD_PERF_EN adds a saturating 32-bit stall-cycle
// counter on stall_cycles; without it stall_cycles is tied to zero.
module hazard_unit #(
  parameter int MULT_MAX_CYCLES = 34,
  parameter int CNT_W           = 6
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hz
);

  localparam logic [2:0]       WB_MEM  = 3'b001;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MULT_MAX_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } multState_t;

  multState_t       multState;
  logic [CNT_W-1:0] busyCnt;
  logic             multErr;

  logic [1:0] fwdAE;
  logic [1:0] fwdBE;
  logic       fwdAD;
  logic       fwdBD;
  logic       lwStall;
  logic       branchStall;
  logic       multStall;
  logic       busyNow;
  logic       stall;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic tagHit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // E-stage operand forwarding: the younger M result wins over W.
  always_comb begin
    fwdAE = 2'b00;
    fwdBE = 2'b00;
    if (hz.RegWriteM && tagHit(hz.WriteRegM, hz.RsE)) begin
      fwdAE = 2'b10;
    end else if (hz.RegWriteW && tagHit(hz.WriteRegW, hz.RsE)) begin
      fwdAE = 2'b01;
    end
    if (hz.RegWriteM && tagHit(hz.WriteRegM, hz.RtE)) begin
      fwdBE = 2'b10;
    end else if (hz.RegWriteW && tagHit(hz.WriteRegW, hz.RtE)) begin
      fwdBE = 2'b01;
    end
  end

  // D-stage branch comparator operands can only be bypassed from ALUOutM.
  always_comb begin
    fwdAD = hz.RegWriteM && tagHit(hz.WriteRegM, hz.RsD);
    fwdBD = hz.RegWriteM && tagHit(hz.WriteRegM, hz.RtD);
  end

  // Stall sources: load-use, unresolved branch operands, and multiplier busy.
  // A branch resolved in D must wait for any E result and for an M load,
  // since neither is available on the ALUOutM bypass yet.
  always_comb begin
    lwStall = (hz.WBSrcE == WB_MEM) && hz.RegWriteE &&
              (tagHit(hz.WriteRegE, hz.RsD) || tagHit(hz.WriteRegE, hz.RtD));

    branchStall = (hz.branchD != 2'b00) &&
                  ((hz.RegWriteE &&
                    (tagHit(hz.WriteRegE, hz.RsD) || tagHit(hz.WriteRegE, hz.RtD))) ||
                   ((hz.WBSrcM == WB_MEM) && hz.RegWriteM &&
                    (tagHit(hz.WriteRegM, hz.RsD) || tagHit(hz.WriteRegM, hz.RtD))));

    // The done cycle still counts as busy: HI/LO are written at its closing
    // edge, so a reader is released only on the following cycle.
    busyNow   = (multState == BUSY) || hz.MultStartE;
    multStall = (hz.HiLoReadD || hz.MultStartD) && busyNow;

    stall = lwStall || branchStall || multStall;
  end

  // Multiplier tracker: counts busy cycles, restarts on back-to-back mults,
  // and gives up with a sticky error once the busy budget is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multState <= IDLE;
      busyCnt   <= '0;
      multErr   <= 1'b0;
    end else begin
      case (multState)
        IDLE: begin
          if (hz.MultStartE) begin
            multState <= BUSY;
            busyCnt   <= CNT_ONE;
          end
        end
        BUSY: begin
          if (hz.MultDoneE && hz.MultStartE) begin
            busyCnt <= CNT_ONE;
          end else if (hz.MultDoneE) begin
            multState <= IDLE;
            busyCnt   <= '0;
          end else if (busyCnt == CNT_MAX) begin
            multState <= IDLE;
            busyCnt   <= '0;
            multErr   <= 1'b1;
          end else begin
            busyCnt <= busyCnt + CNT_ONE;
          end
        end
        default: begin
          multState <= IDLE;
          busyCnt   <= '0;
        end
      endcase
    end
  end

  // Drive the controls; everything is forced low while reset is held.
  always_comb begin
    hz.stallF    = stall && !rst;
    hz.stallD    = stall && !rst;
    hz.flushE    = stall && !rst;
    hz.forwardAD = fwdAD && !rst;
    hz.forwardBD = fwdBD && !rst;
    hz.forwardAE = rst ? 2'b00 : fwdAE;
    hz.forwardBE = rst ? 2'b00 : fwdBE;
    hz.mult_err  = multErr;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt;

  // Count every clock edge that sees a stall, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign hz.stall_cycles = stallCnt;
`else
  assign hz.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: forwarding priority, load-use and
// branch stalls, multiplier busy tracking, timeout, asynchronous reset and
// the optional stall-cycle counter (HAZARD_PERF_EN).
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;

  int testCount = 0;
  int failCount = 0;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] PERF_EXPECT_3  = 32'd3;
  localparam logic [31:0] PERF_EXPECT_23 = 32'd23;
`else
  localparam logic [31:0] PERF_EXPECT_3  = 32'd0;
  localparam logic [31:0] PERF_EXPECT_23 = 32'd0;
`endif

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  hazard_unit_if busIf ();

  hazard_unit #(
    .MULT_MAX_CYCLES(34),
    .CNT_W          (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (busIf.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStall(input string tag, input logic expected);
    checkOutput({tag, ".stallF"}, 32'(busIf.stallF), 32'(expected));
    checkOutput({tag, ".stallD"}, 32'(busIf.stallD), 32'(expected));
    checkOutput({tag, ".flushE"}, 32'(busIf.flushE), 32'(expected));
  endtask

  task automatic clearInputs();
    busIf.branchD    = 2'b00;
    busIf.RsD        = 5'd0;
    busIf.RtD        = 5'd0;
    busIf.HiLoReadD  = 1'b0;
    busIf.MultStartD = 1'b0;
    busIf.RsE        = 5'd0;
    busIf.RtE        = 5'd0;
    busIf.WriteRegE  = 5'd0;
    busIf.RegWriteE  = 1'b0;
    busIf.WBSrcE     = 3'b000;
    busIf.MultStartE = 1'b0;
    busIf.MultDoneE  = 1'b0;
    busIf.WriteRegM  = 5'd0;
    busIf.RegWriteM  = 1'b0;
    busIf.WBSrcM     = 3'b000;
    busIf.WriteRegW  = 5'd0;
    busIf.RegWriteW  = 1'b0;
  endtask

  // Advance one clock: inputs change 2 ns after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset holds every output low even with hazard-causing inputs
    rst = 1'b1;
    clearInputs();
    busIf.RegWriteM = 1'b1;
    busIf.WriteRegM = 5'd8;
    busIf.RsE       = 5'd8;
    busIf.RsD       = 5'd8;
    busIf.HiLoReadD = 1'b1;
    busIf.MultStartE = 1'b1;
    #3;
    checkOutput("rst.forwardAE", 32'(busIf.forwardAE), 32'd0);
    checkOutput("rst.forwardAD", 32'(busIf.forwardAD), 32'd0);
    checkStall("rst", 1'b0);
    checkOutput("rst.mult_err", 32'(busIf.mult_err), 32'd0);
    checkOutput("rst.stall_cycles", busIf.stall_cycles, 32'd0);
    applyStimulus();
    clearInputs();
    rst = 1'b0;
    settle();
    checkStall("idle", 1'b0);

    // E-stage forwarding: M beats W, W alone, register 0 never matches
    applyStimulus();
    busIf.RegWriteM = 1'b1;
    busIf.WriteRegM = 5'd8;
    busIf.RegWriteW = 1'b1;
    busIf.WriteRegW = 5'd8;
    busIf.RsE       = 5'd8;
    busIf.RtE       = 5'd8;
    settle();
    checkOutput("fwd.M.AE", 32'(busIf.forwardAE), 32'd2);
    checkOutput("fwd.M.BE", 32'(busIf.forwardBE), 32'd2);
    busIf.RegWriteM = 1'b0;
    settle();
    checkOutput("fwd.W.AE", 32'(busIf.forwardAE), 32'd1);
    checkOutput("fwd.W.BE", 32'(busIf.forwardBE), 32'd1);
    busIf.RsE = 5'd0;
    busIf.WriteRegW = 5'd0;
    busIf.RtE = 5'd0;
    settle();
    checkOutput("fwd.r0.AE", 32'(busIf.forwardAE), 32'd0);
    checkOutput("fwd.r0.BE", 32'(busIf.forwardBE), 32'd0);
    busIf.RegWriteW = 1'b1;
    busIf.WriteRegW = 5'd3;
    busIf.RtE = 5'd3;
    busIf.RsE = 5'd7;
    settle();
    checkOutput("fwd.Wonly.AE", 32'(busIf.forwardAE), 32'd0);
    checkOutput("fwd.Wonly.BE", 32'(busIf.forwardBE), 32'd1);

    // D-stage forwarding from ALUOutM
    clearInputs();
    busIf.RegWriteM = 1'b1;
    busIf.WriteRegM = 5'd5;
    busIf.RsD       = 5'd5;
    busIf.RtD       = 5'd6;
    settle();
    checkOutput("fwdD.AD", 32'(busIf.forwardAD), 32'd1);
    checkOutput("fwdD.BD", 32'(busIf.forwardBD), 32'd0);
    busIf.RsD = 5'd6;
    busIf.RtD = 5'd5;
    settle();
    checkOutput("fwdD.swap.AD", 32'(busIf.forwardAD), 32'd0);
    checkOutput("fwdD.swap.BD", 32'(busIf.forwardBD), 32'd1);
    busIf.WriteRegM = 5'd0;
    busIf.RsD = 5'd0;
    busIf.RtD = 5'd0;
    settle();
    checkOutput("fwdD.r0.AD", 32'(busIf.forwardAD), 32'd0);
    checkOutput("fwdD.r0.BD", 32'(busIf.forwardBD), 32'd0);

    // Load-use stall for one cycle, then the bubble clears it
    applyStimulus();
    clearInputs();
    busIf.WBSrcE    = 3'b001;
    busIf.RegWriteE = 1'b1;
    busIf.WriteRegE = 5'd9;
    busIf.RtD       = 5'd9;
    settle();
    checkStall("lw", 1'b1);
    applyStimulus();
    busIf.WBSrcE    = 3'b000;
    busIf.RegWriteE = 1'b0;
    busIf.WriteRegE = 5'd0;
    settle();
    checkStall("lw.flushed", 1'b0);
    busIf.RegWriteE = 1'b1;
    busIf.WriteRegE = 5'd9;
    settle();
    checkStall("lw.aluSrc", 1'b0);

    // Branch stalls on an E producer, then takes the M bypass
    applyStimulus();
    clearInputs();
    busIf.branchD   = 2'b01;
    busIf.RsD       = 5'd4;
    busIf.RegWriteE = 1'b1;
    busIf.WriteRegE = 5'd4;
    settle();
    checkStall("br.E", 1'b1);
    applyStimulus();
    busIf.RegWriteE = 1'b0;
    busIf.WriteRegE = 5'd0;
    busIf.RegWriteM = 1'b1;
    busIf.WriteRegM = 5'd4;
    busIf.WBSrcM    = 3'b000;
    settle();
    checkStall("br.M", 1'b0);
    checkOutput("br.M.AD", 32'(busIf.forwardAD), 32'd1);
    busIf.WBSrcM = 3'b001;
    settle();
    checkStall("br.Mload", 1'b1);
    busIf.branchD = 2'b00;
    settle();
    checkStall("br.none", 1'b0);

    // Multiply: HI/LO reader held from start cycle through done cycle
    applyStimulus();
    clearInputs();
    busIf.MultStartE = 1'b1;
    busIf.HiLoReadD  = 1'b1;
    settle();
    checkStall("mul.c0", 1'b1);
    for (int i = 1; i < 20; i++) begin
      applyStimulus();
      busIf.MultStartE = 1'b0;
      settle();
      checkStall($sformatf("mul.c%0d", i), 1'b1);
    end
    applyStimulus();
    busIf.MultDoneE = 1'b1;
    settle();
    checkStall("mul.c20.done", 1'b1);
    applyStimulus();
    busIf.MultDoneE = 1'b0;
    settle();
    checkStall("mul.c21", 1'b0);
    busIf.HiLoReadD  = 1'b0;
    busIf.MultStartD = 1'b1;
    settle();
    checkStall("mul.idleMultD", 1'b0);
    busIf.MultDoneE = 1'b1;
    applyStimulus();
    busIf.MultDoneE = 1'b0;
    settle();
    checkStall("mul.doneInIdle", 1'b0);

    // Back-to-back multiply keeps the tracker busy
    busIf.MultStartD = 1'b0;
    busIf.MultStartE = 1'b1;
    applyStimulus();
    busIf.MultStartE = 1'b0;
    applyStimulus();
    busIf.MultStartE = 1'b1;
    busIf.MultDoneE  = 1'b1;
    applyStimulus();
    busIf.MultStartE = 1'b0;
    busIf.MultDoneE  = 1'b0;
    busIf.MultStartD = 1'b1;
    settle();
    checkStall("b2b.busy", 1'b1);
    busIf.MultDoneE = 1'b1;
    applyStimulus();
    busIf.MultDoneE = 1'b0;
    settle();
    checkStall("b2b.released", 1'b0);
    checkOutput("b2b.mult_err", 32'(busIf.mult_err), 32'd0);

    // Timeout: busy for cycles 1..34 after the start edge, error in cycle 35
    applyStimulus();
    clearInputs();
    busIf.MultStartE = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      applyStimulus();
      busIf.MultStartE = 1'b0;
      busIf.MultStartD = 1'b1;
      settle();
      if (i == 1 || i == 33 || i == 34) begin
        checkOutput($sformatf("tmo.c%0d.mult_err", i), 32'(busIf.mult_err), 32'd0);
        checkStall($sformatf("tmo.c%0d", i), 1'b1);
      end
    end
    applyStimulus();
    settle();
    checkOutput("tmo.c35.mult_err", 32'(busIf.mult_err), 32'd1);
    checkStall("tmo.c35.idle", 1'b0);
    applyStimulus();
    applyStimulus();
    checkOutput("tmo.sticky", 32'(busIf.mult_err), 32'd1);

    // Reset mid-BUSY abandons the multiply immediately
    clearInputs();
    pulseReset();
    checkOutput("rst2.mult_err", 32'(busIf.mult_err), 32'd0);
    applyStimulus();
    busIf.MultStartE = 1'b1;
    applyStimulus();
    busIf.MultStartE = 1'b0;
    busIf.MultStartD = 1'b1;
    busIf.RegWriteM  = 1'b1;
    busIf.WriteRegM  = 5'd12;
    busIf.RsE        = 5'd12;
    settle();
    checkStall("rstBusy.pre", 1'b1);
    rst = 1'b1;
    #1;
    checkStall("rstBusy.during", 1'b0);
    checkOutput("rstBusy.forwardAE", 32'(busIf.forwardAE), 32'd0);
    checkOutput("rstBusy.mult_err", 32'(busIf.mult_err), 32'd0);
    rst = 1'b0;
    #1;
    checkStall("rstBusy.after", 1'b0);
    checkOutput("rstBusy.after.AE", 32'(busIf.forwardAE), 32'd2);

    // Stall-cycle counter: 3 load-use stalls plus a 20-cycle multstall
    clearInputs();
    pulseReset();
    checkOutput("perf.cleared", busIf.stall_cycles, 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      busIf.WBSrcE    = 3'b001;
      busIf.RegWriteE = 1'b1;
      busIf.WriteRegE = 5'd10;
      busIf.RsD       = 5'd10;
      applyStimulus();
      clearInputs();
    end
    settle();
    checkOutput("perf.lw3", busIf.stall_cycles, PERF_EXPECT_3);
    busIf.MultStartE = 1'b1;
    busIf.HiLoReadD  = 1'b1;
    for (int i = 1; i < 20; i++) begin
      applyStimulus();
      busIf.MultStartE = 1'b0;
      busIf.MultDoneE  = (i == 19);
    end
    applyStimulus();
    clearInputs();
    applyStimulus();
    settle();
    checkOutput("perf.total", busIf.stall_cycles, PERF_EXPECT_23);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
